// File: rtl/dma_queue.sv
// Queued DMA command engine: buffers d2s/s2d/fill commands from the core and
// moves them word by word between the DRAM and SRAM ports. Fill behaviour is enabled by DMA_FILL_EN.
module dma_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_W-1:0]        cmd_src,
  input  logic [ADDR_W-1:0]        cmd_dst,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     fence,
  output logic                     stall,
  output logic                     cmd_ready,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     dram_req,
  output logic                     dram_we,
  output logic [ADDR_W-1:0]        dram_addr,
  output logic [DATA_W-1:0]        dram_wdata,
  input  logic [DATA_W-1:0]        dram_rdata,
  input  logic                     dram_ack,
  output logic                     sram_req,
  output logic                     sram_we,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic [DATA_W-1:0]        sram_rdata,
  input  logic                     sram_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef DMA_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_D2S  = 2'b01,
    OP_S2D  = 2'b10,
    OP_FILL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem [DEPTH];
  cmd_t             head;
  cmd_t             incoming;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, push, pop;

  state_t            state, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              is_d2s, is_s2d;
  logic              rd_ack, wr_ack;
  logic [DATA_W-1:0] rd_data;

  assign full     = (count == CNT_W'(DEPTH));
  assign push     = (cmd_op != 2'b00) && !full;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign head     = mem[rd_ptr];
  assign incoming = '{op: op_t'(cmd_op), src: cmd_src, dst: cmd_dst, len: cmd_len};

  // NOTE: storage carries no reset; validity is tracked by count and the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= incoming;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer engine
  // ---------------------------------------------------------------------------
  assign is_d2s  = (op_q == OP_D2S);
  assign is_s2d  = (op_q == OP_S2D);
  assign rd_ack  = is_d2s ? dram_ack : sram_ack;
  assign wr_ack  = is_s2d ? dram_ack : sram_ack;
  assign rd_data = is_d2s ? dram_rdata : sram_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op_q  <= OP_NONE;
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      buf_q <= '0;
    end else begin
      state <= state_d;
      op_q  <= op_d;
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      buf_q <= buf_d;
    end
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state)
      S_IDLE: begin
        if (pop) begin
          op_d  = head.op;
          src_d = head.src;
          dst_d = head.dst;
          rem_d = head.len;
          // A fill carries its data word in the source field.
          buf_d = DATA_W'(head.src);
          if (head.len == '0 || (head.op == OP_FILL && !FILL_EN)) state_d = S_DONE;
          else if (head.op == OP_FILL)                                state_d = S_WRITE;
          else                                                        state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_ack) begin
          buf_d   = rd_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ack) begin
          dst_d = dst_q + ADDR_W'(4);
          if (op_q != OP_FILL) src_d = src_q + ADDR_W'(4);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1))    state_d = S_DONE;
          else if (op_q == OP_FILL)  state_d = S_WRITE;
          else                       state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port drive: reads come from the source side, writes (fill included) go to the destination side.
  always_comb begin
    dram_req   = 1'b0;
    dram_we    = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state == S_READ) begin
      if (is_d2s) begin
        dram_req  = 1'b1;
        dram_addr = src_q;
      end else begin
        sram_req  = 1'b1;
        sram_addr = src_q;
      end
    end else if (state == S_WRITE) begin
      if (is_s2d) begin
        dram_req   = 1'b1;
        dram_we    = 1'b1;
        dram_addr  = dst_q;
        dram_wdata = buf_q;
      end else begin
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = dst_q;
        sram_wdata = buf_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Core-facing status
  // ---------------------------------------------------------------------------
  assign pending   = count + CNT_W'(state != S_IDLE);
  assign busy      = (pending != '0);
  assign done      = (state == S_DONE);
  assign cmd_ready = !full;
  assign stall     = ((cmd_op != 2'b00) && full) || (fence && busy);

endmodule
